// File: rtl/color_centroid_if.sv
// Bundle of the frame/pixel inputs and classification/result outputs of the
// colour centroid accumulator. The producer uses master, the accumulator uses slave.
interface color_centroid_if #(
  parameter int CW    = 3,
  parameter int XW    = 10,
  parameter int YW    = 10,
  parameter int CNT_W = XW + YW
);
  logic                  frame_start;
  logic                  frame_end;
  logic                  pix_valid;
  logic [3*CW-1:0]       pix_data;
  logic [XW-1:0]         pix_x;
  logic [YW-1:0]         pix_y;

  logic                  class_valid;
  logic [2:0]            class_flags;
  logic [CNT_W-1:0]      cnt_r, cnt_g, cnt_b;
  logic [XW+CNT_W-1:0]   sumx_r, sumx_g, sumx_b;
  logic [YW+CNT_W-1:0]   sumy_r, sumy_g, sumy_b;
  logic                  result_valid;
  logic [2:0]            overflow;
  logic                  busy;

  modport master (
    output frame_start, frame_end, pix_valid, pix_data, pix_x, pix_y,
    input  class_valid, class_flags, cnt_r, cnt_g, cnt_b,
           sumx_r, sumx_g, sumx_b, sumy_r, sumy_g, sumy_b,
           result_valid, overflow, busy
  );

  modport slave (
    input  frame_start, frame_end, pix_valid, pix_data, pix_x, pix_y,
    output class_valid, class_flags, cnt_r, cnt_g, cnt_b,
           sumx_r, sumx_g, sumx_b, sumy_r, sumy_g, sumy_b,
           result_valid, overflow, busy
  );
endinterface

// File: rtl/color_centroid_accumulator.sv
// Classifies pixels by dominant colour and accumulates per-colour pixel counts
// and coordinate sums over a frame, reporting saturating results at frame end.
module color_centroid_accumulator #(
  parameter int CW          = 3,
  parameter int XW          = 10,
  parameter int YW          = 10,
  parameter int RATIO_SHIFT = 1,
  parameter int MIN_LEVEL   = 0,
  parameter int CNT_W       = XW + YW
) (
  input logic             clk,
  input logic             reset,
  color_centroid_if.slave bus
);

  localparam int SXW = XW + CNT_W;
  localparam int SYW = YW + CNT_W;
  localparam int WW  = CW + RATIO_SHIFT;
  localparam logic [31:0] MIN_L = 32'(MIN_LEVEL);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, REPORT} state_t;

  // Comparison is done at CW+RATIO_SHIFT bits so the scaled rivals never truncate.
  function automatic logic dominant(input logic [CW-1:0] c, o1, o2);
    logic [WW-1:0] cw, a, b;
    cw = WW'(c);
    a  = WW'(o1) << RATIO_SHIFT;
    b  = WW'(o2) << RATIO_SHIFT;
    return (cw >= a) && (cw >= b) && (32'(c) >= MIN_L);
  endfunction

  logic [CW-1:0] ch_r, ch_g, ch_b;
  logic [2:0]    flags_d;

  assign ch_r    = bus.pix_data[3*CW-1 -: CW];
  assign ch_g    = bus.pix_data[2*CW-1 -: CW];
  assign ch_b    = bus.pix_data[CW-1:0];
  assign flags_d = {dominant(ch_r, ch_g, ch_b),
                    dominant(ch_g, ch_r, ch_b),
                    dominant(ch_b, ch_r, ch_g)};

  state_t state, state_nx;
  logic   flush_cnt;
  logic   clear, load_out;

  // Stage 1: classifier register, free-running in every state.
  logic          s1_valid, s1_acc;
  logic [2:0]    s1_flags;
  logic [XW-1:0] s1_x;
  logic [YW-1:0] s1_y;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement or block order.
    if (reset) begin
      s1_valid <= 1'b0;
      s1_acc   <= 1'b0;
      s1_flags <= '0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else begin
      s1_valid <= bus.pix_valid;
      s1_acc   <= bus.pix_valid && (state == ACCUM) && !bus.frame_start;
      s1_flags <= flags_d;
      s1_x     <= bus.pix_x;
      s1_y     <= bus.pix_y;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can
    // leave one unassigned and infer a latch.
    state_nx = state;
    clear    = 1'b0;
    load_out = 1'b0;
    if (bus.frame_start) begin
      state_nx = ACCUM;
      clear    = 1'b1;
    end else begin
      case (state)
        IDLE:    state_nx = IDLE;
        ACCUM:   if (bus.frame_end) state_nx = FLUSH;
        FLUSH:   if (flush_cnt) begin
                   state_nx = REPORT;
                   load_out = 1'b1;
                 end
        REPORT:  state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      flush_cnt <= 1'b0;
    end else begin
      state     <= state_nx;
      flush_cnt <= (state == FLUSH) && !flush_cnt && !bus.frame_start;
    end
  end

  // Stage 2: saturating accumulators, index 2 = red, 1 = green, 0 = blue.
  logic [CNT_W-1:0] acc_cnt [3];
  logic [SXW-1:0]   acc_sx  [3];
  logic [SYW-1:0]   acc_sy  [3];
  logic [2:0]       acc_ovf;
  logic [CNT_W:0]   cnt_sum [3];
  logic [SXW:0]     sx_sum  [3];
  logic [SYW:0]     sy_sum  [3];

  always_comb begin
    for (int c = 0; c < 3; c++) begin
      cnt_sum[c] = {1'b0, acc_cnt[c]} + (CNT_W+1)'(1);
      sx_sum[c]  = {1'b0, acc_sx[c]} + (SXW+1)'(s1_x);
      sy_sum[c]  = {1'b0, acc_sy[c]} + (SYW+1)'(s1_y);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      acc_ovf <= '0;
      for (int c = 0; c < 3; c++) begin
        acc_cnt[c] <= '0;
        acc_sx[c]  <= '0;
        acc_sy[c]  <= '0;
      end
    end else if (s1_valid && s1_acc) begin
      for (int c = 0; c < 3; c++) begin
        if (s1_flags[c]) begin
          acc_cnt[c] <= cnt_sum[c][CNT_W] ? '1 : cnt_sum[c][CNT_W-1:0];
          acc_sx[c]  <= sx_sum[c][SXW]    ? '1 : sx_sum[c][SXW-1:0];
          acc_sy[c]  <= sy_sum[c][SYW]    ? '1 : sy_sum[c][SYW-1:0];
          acc_ovf[c] <= acc_ovf[c] | cnt_sum[c][CNT_W] | sx_sum[c][SXW] | sy_sum[c][SYW];
        end
      end
    end
  end

  // Results are captured on entry to REPORT so they are stable while result_valid is high.
  logic [CNT_W-1:0] out_cnt [3];
  logic [SXW-1:0]   out_sx  [3];
  logic [SYW-1:0]   out_sy  [3];
  logic [2:0]       out_ovf;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_ovf <= '0;
      for (int c = 0; c < 3; c++) begin
        out_cnt[c] <= '0;
        out_sx[c]  <= '0;
        out_sy[c]  <= '0;
      end
    end else if (load_out) begin
      out_ovf <= acc_ovf;
      for (int c = 0; c < 3; c++) begin
        out_cnt[c] <= acc_cnt[c];
        out_sx[c]  <= acc_sx[c];
        out_sy[c]  <= acc_sy[c];
      end
    end
  end

  assign bus.class_valid  = s1_valid;
  assign bus.class_flags  = s1_flags;
  assign bus.result_valid = (state == REPORT);
  assign bus.busy         = (state == ACCUM) || (state == FLUSH);
  assign bus.overflow     = out_ovf;
  assign bus.cnt_r        = out_cnt[2];
  assign bus.cnt_g        = out_cnt[1];
  assign bus.cnt_b        = out_cnt[0];
  assign bus.sumx_r       = out_sx[2];
  assign bus.sumx_g       = out_sx[1];
  assign bus.sumx_b       = out_sx[0];
  assign bus.sumy_r       = out_sy[2];
  assign bus.sumy_g       = out_sy[1];
  assign bus.sumy_b       = out_sy[0];

endmodule

// File: tb/tb_color_centroid_accumulator.sv
// Scoreboard bench: drivers push expected flags/results, a negedge monitor pops
// and compares whenever class_valid or result_valid is presented.
module tb_color_centroid_accumulator;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  color_centroid_if #(.CW(3), .XW(10), .YW(10)) bus0 ();
  color_centroid_if #(.CW(3), .XW(10), .YW(10)) bus1 ();
  color_centroid_if #(.CW(3), .XW(2),  .YW(2))  bus2 ();

  color_centroid_accumulator u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  color_centroid_accumulator #(.MIN_LEVEL(3)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));
  color_centroid_accumulator #(.XW(2), .YW(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2));

  assign bus1.frame_start = bus0.frame_start;
  assign bus1.frame_end   = bus0.frame_end;
  assign bus1.pix_valid   = bus0.pix_valid;
  assign bus1.pix_data    = bus0.pix_data;
  assign bus1.pix_x       = bus0.pix_x;
  assign bus1.pix_y       = bus0.pix_y;

  typedef struct {
    int         cyc;
    logic [2:0] flags;
  } flag_t;

  typedef struct {
    int               cyc;
    logic [2:0][31:0] cnt;
    logic [2:0][31:0] sx;
    logic [2:0][31:0] sy;
    logic [2:0]       ovf;
  } res_t;

  flag_t q_f0[$];
  flag_t q_f1[$];
  res_t  q_r0[$];
  res_t  q_r2[$];
  string cn[3] = '{"b", "g", "r"};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: output presented with nothing expected (cycle %0d)", name, cyc);
  endtask

  function automatic res_t mk(input int cr, sxr, syr, cg, sxg, syg, cb, sxb, syb,
                              input logic [2:0] ov);
    res_t r;
    r.cyc = 0;
    r.cnt[2] = 32'(cr); r.sx[2] = 32'(sxr); r.sy[2] = 32'(syr);
    r.cnt[1] = 32'(cg); r.sx[1] = 32'(sxg); r.sy[1] = 32'(syg);
    r.cnt[0] = 32'(cb); r.sx[0] = 32'(sxb); r.sy[0] = 32'(syb);
    r.ovf = ov;
    return r;
  endfunction

  task automatic cmp_res(input string tag, input res_t a, input res_t e);
    check({tag, "_cycle"}, a.cyc, e.cyc);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("%s_cnt_%s", tag, cn[c]),  a.cnt[c], e.cnt[c]);
      check($sformatf("%s_sumx_%s", tag, cn[c]), a.sx[c],  e.sx[c]);
      check($sformatf("%s_sumy_%s", tag, cn[c]), a.sy[c],  e.sy[c]);
    end
    check({tag, "_overflow"}, 32'(a.ovf), 32'(e.ovf));
  endtask

  // Monitor: decoupled from the drivers, samples on the falling edge.
  always @(negedge clk) begin
    flag_t f;
    res_t  a, e;
    if (bus0.class_valid) begin
      if (q_f0.size() == 0) unexpected("flags0");
      else begin
        f = q_f0.pop_front();
        check("flags0", 32'(bus0.class_flags), 32'(f.flags));
        check("flags0_cycle", cyc, f.cyc);
      end
    end
    if (bus1.class_valid) begin
      if (q_f1.size() == 0) unexpected("flags_minlvl3");
      else begin
        f = q_f1.pop_front();
        check("flags_minlvl3", 32'(bus1.class_flags), 32'(f.flags));
      end
    end
    if (bus0.result_valid) begin
      if (q_r0.size() == 0) unexpected("result0");
      else begin
        e = q_r0.pop_front();
        a.cyc = cyc;
        a.cnt[2] = 32'(bus0.cnt_r); a.sx[2] = 32'(bus0.sumx_r); a.sy[2] = 32'(bus0.sumy_r);
        a.cnt[1] = 32'(bus0.cnt_g); a.sx[1] = 32'(bus0.sumx_g); a.sy[1] = 32'(bus0.sumy_g);
        a.cnt[0] = 32'(bus0.cnt_b); a.sx[0] = 32'(bus0.sumx_b); a.sy[0] = 32'(bus0.sumy_b);
        a.ovf = bus0.overflow;
        cmp_res("result0", a, e);
      end
    end
    if (bus2.result_valid) begin
      if (q_r2.size() == 0) unexpected("result_small");
      else begin
        e = q_r2.pop_front();
        a.cyc = cyc;
        a.cnt[2] = 32'(bus2.cnt_r); a.sx[2] = 32'(bus2.sumx_r); a.sy[2] = 32'(bus2.sumy_r);
        a.cnt[1] = 32'(bus2.cnt_g); a.sx[1] = 32'(bus2.sumx_g); a.sy[1] = 32'(bus2.sumy_g);
        a.cnt[0] = 32'(bus2.cnt_b); a.sx[0] = 32'(bus2.sumx_b); a.sy[0] = 32'(bus2.sumy_b);
        a.ovf = bus2.overflow;
        cmp_res("result_small", a, e);
      end
    end
  end

  // Drivers: each call occupies exactly one clock cycle.
  task automatic drive0(input logic fs, fe, pv, input logic [8:0] d, input int x, y,
                        input logic [2:0] e0, e1);
    bus0.frame_start = fs;
    bus0.frame_end   = fe;
    bus0.pix_valid   = pv;
    bus0.pix_data    = d;
    bus0.pix_x       = 10'(x);
    bus0.pix_y       = 10'(y);
    if (pv) begin
      q_f0.push_back('{cyc + 1, e0});
      q_f1.push_back('{cyc + 1, e1});
    end
    @(posedge clk);
    #1;
    bus0.frame_start = 1'b0;
    bus0.frame_end   = 1'b0;
    bus0.pix_valid   = 1'b0;
  endtask

  task automatic idle0(input int n);
    repeat (n) drive0(1'b0, 1'b0, 1'b0, 9'd0, 0, 0, 3'b000, 3'b000);
  endtask

  task automatic start0();
    drive0(1'b1, 1'b0, 1'b0, 9'd0, 0, 0, 3'b000, 3'b000);
  endtask

  task automatic pix0(input logic [8:0] d, input int x, y, input logic [2:0] e0, e1);
    drive0(1'b0, 1'b0, 1'b1, d, x, y, e0, e1);
  endtask

  task automatic end0(input logic pv, input logic [8:0] d, input int x, y,
                      input logic [2:0] e0, e1, input res_t r);
    r.cyc = cyc + 3;
    q_r0.push_back(r);
    drive0(1'b0, 1'b1, pv, d, x, y, e0, e1);
  endtask

  task automatic drive2(input logic fs, fe, pv, input logic [8:0] d, input int x, y);
    bus2.frame_start = fs;
    bus2.frame_end   = fe;
    bus2.pix_valid   = pv;
    bus2.pix_data    = d;
    bus2.pix_x       = 2'(x);
    bus2.pix_y       = 2'(y);
    @(posedge clk);
    #1;
    bus2.frame_start = 1'b0;
    bus2.frame_end   = 1'b0;
    bus2.pix_valid   = 1'b0;
  endtask

  task automatic end2(input res_t r);
    r.cyc = cyc + 3;
    q_r2.push_back(r);
    drive2(1'b0, 1'b1, 1'b0, 9'd0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus0.frame_start = 1'b0; bus0.frame_end = 1'b0; bus0.pix_valid = 1'b0;
    bus0.pix_data = '0; bus0.pix_x = '0; bus0.pix_y = '0;
    bus2.frame_start = 1'b0; bus2.frame_end = 1'b0; bus2.pix_valid = 1'b0;
    bus2.pix_data = '0; bus2.pix_x = '0; bus2.pix_y = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus0.busy), 0);
    check("rst_result_valid", 32'(bus0.result_valid), 0);
    check("rst_class_valid", 32'(bus0.class_valid), 0);
    check("rst_overflow", 32'(bus0.overflow), 0);
    check("rst_cnt_r", 32'(bus0.cnt_r), 0);
    reset = 1'b0;
    idle0(2);

    // IDLE: pixel is classified but not accumulated; frame_end ignored.
    pix0(9'b010_000_000, 50, 60, 3'b100, 3'b000);
    drive0(1'b0, 1'b1, 1'b0, 9'd0, 0, 0, 3'b000, 3'b000);
    idle0(4);
    check("idle_busy", 32'(bus0.busy), 0);

    // Basic frame: one red and one blue pixel.
    start0();
    check("accum_busy", 32'(bus0.busy), 1);
    pix0(9'b110_001_000, 10, 20, 3'b100, 3'b100);
    pix0(9'b000_000_111, 30, 40, 3'b001, 3'b001);
    end0(1'b0, 9'd0, 0, 0, 3'b000, 3'b000, mk(1, 10, 20, 0, 0, 0, 1, 30, 40, 3'b000));
    idle0(8);
    check("hold_cnt_r", 32'(bus0.cnt_r), 1);
    check("hold_sumx_b", 32'(bus0.sumx_b), 30);

    // Multi-flag pixel, pixel with frame_end counted, pixel after it not.
    start0();
    pix0(9'b000_000_000, 1, 2, 3'b111, 3'b000);
    pix0(9'b000_011_000, 5, 6, 3'b010, 3'b010);
    end0(1'b1, 9'b101_010_000, 7, 8, 3'b100, 3'b100,
         mk(2, 8, 10, 2, 6, 8, 1, 1, 2, 3'b000));
    pix0(9'b000_000_100, 100, 100, 3'b001, 3'b001);
    idle0(6);

    // Restart mid-frame discards the first five pixels.
    start0();
    repeat (5) pix0(9'b110_001_000, 1, 1, 3'b100, 3'b100);
    start0();
    repeat (2) pix0(9'b110_001_000, 2, 3, 3'b100, 3'b100);
    end0(1'b0, 9'd0, 0, 0, 3'b000, 3'b000, mk(2, 4, 6, 0, 0, 0, 0, 0, 0, 3'b000));
    idle0(6);

    // frame_start and frame_end together: frame_start wins.
    start0();
    pix0(9'b110_001_000, 9, 9, 3'b100, 3'b100);
    drive0(1'b1, 1'b1, 1'b0, 9'd0, 0, 0, 3'b000, 3'b000);
    pix0(9'b000_000_111, 3, 4, 3'b001, 3'b001);
    end0(1'b0, 9'd0, 0, 0, 3'b000, 3'b000, mk(0, 0, 0, 0, 0, 0, 1, 3, 4, 3'b000));
    idle0(6);

    // Reset in FLUSH (together with frame_start) aborts with no report.
    start0();
    pix0(9'b110_001_000, 1, 1, 3'b100, 3'b100);
    drive0(1'b0, 1'b1, 1'b0, 9'd0, 0, 0, 3'b000, 3'b000);
    check("flush_busy", 32'(bus0.busy), 1);
    reset = 1'b1;
    bus0.frame_start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus0.frame_start = 1'b0;
    check("rstflush_busy", 32'(bus0.busy), 0);
    check("rstflush_result_valid", 32'(bus0.result_valid), 0);
    check("rstflush_cnt_b", 32'(bus0.cnt_b), 0);
    check("rstflush_sumx_b", 32'(bus0.sumx_b), 0);
    idle0(6);

    // Narrow instance: count saturates at 15, overflow is per frame.
    drive2(1'b1, 1'b0, 1'b0, 9'd0, 0, 0);
    repeat (20) drive2(1'b0, 1'b0, 1'b1, 9'b110_001_000, 1, 1);
    end2(mk(15, 20, 20, 0, 0, 0, 0, 0, 0, 3'b100));
    repeat (6) drive2(1'b0, 1'b0, 1'b0, 9'd0, 0, 0);
    drive2(1'b1, 1'b0, 1'b0, 9'd0, 0, 0);
    drive2(1'b0, 1'b0, 1'b1, 9'b110_001_000, 2, 3);
    end2(mk(1, 2, 3, 0, 0, 0, 0, 0, 0, 3'b000));
    repeat (8) drive2(1'b0, 1'b0, 1'b0, 9'd0, 0, 0);

    check("q_flags0_left", q_f0.size(), 0);
    check("q_flags1_left", q_f1.size(), 0);
    check("q_result0_left", q_r0.size(), 0);
    check("q_result_small_left", q_r2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
